fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Responder end of the DIR/DOR/ack pipeline handshake. Accepts fetch addresses (PC) from an initiator,
//  reads each one through a memory_controller device port (en/addr/di/do_ack/mem_do), and returns the fetched
//  byte with DOR held until the initiator acks. A small address queue lets the initiator issue a new PC
//  in the same cycle it acks the previous result.
// PARAMETERS
//  AW       8   address width (mem_addr, data_in)
//  DW       8   data width (mem_do, data_out)
//  QDEPTH   2   address queue depth; power of 2, >=2
//  TIMEOUT  16  cycles mem_en may stay high before abort (FETCH_TIMEOUT_EN only)
// PORTS
//  clk         in   1   clock; all logic on posedge
//  reset       in   1   synchronous, active-high reset
//  dir         in   1   data-in-ready: data_in valid this cycle (1-cycle pulse or level; sampled every cycle)
//  data_in     in   AW  fetch address
//  ack_in      out  1   1-cycle pulse, cycle after a dir was accepted into the queue
//  overflow    out  1   sticky: a dir was dropped because the queue was full; cleared by reset only
//  dor         out  1   data-out-ready; held high until ack_out sampled high
//  ack_out     in   1   initiator consumed data_out; ignored while dor=0
//  data_out    out  DW  fetched byte; stable while dor=1
//  err         out  1   valid with dor: 1 = fetch aborted by timeout (FETCH_TIMEOUT_EN only, else tied 0)
//  mem_en      out  1   memory request; held until mem_do_ack
//  mem_addr    out  AW  request address; stable while mem_en=1
//  mem_di      out  DW  tied 0 (read-only device)
//  mem_do_ack  in   1   memory data valid this cycle; ignored unless in WAIT
//  mem_do      in   DW  memory read data, captured on mem_do_ack
// BEHAVIOUR
//  Reset: all outputs 0, queue empty, FSM=IDLE; any outstanding request is abandoned (late do_ack ignored).
//  Queue: enqueue on dir when not full, or when full and a dequeue occurs the same cycle. Otherwise the
//   address is dropped: overflow<=1, no ack_in. Pointers are log2(QDEPTH)+1 bits and wrap modulo 2*QDEPTH.
//  FSM (registered outputs):
//   IDLE: queue non-empty -> dequeue, mem_addr<=head, mem_en<=1, -> WAIT.
//   WAIT: mem_do_ack -> mem_en<=0, data_out<=mem_do, dor<=1, err<=0, -> HOLD.
//   HOLD: ack_out -> dor<=0; queue non-empty -> dequeue, mem_en<=1 (back-to-back, no IDLE bubble),
//    -> WAIT; else -> IDLE.
//  Latency: dir at cycle n -> ack_in and queue entry visible at n+1 -> mem_en high at n+2 (queue was empty,
//   FSM idle). mem_do_ack at m -> dor high at m+1. ack_out at k -> dor low at k+1, next mem_en at k+1.
//  Simultaneous: dir + ack_out in same cycle: both processed; the new address is fetched after queued ones.
//   dir while in WAIT/HOLD: queued normally. Fetches are strictly in order, one outstanding at a time.
//  mem_do_ack in the same cycle mem_en first rises: accepted (controller may respond combinationally).
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined: a wait counter (clog2(TIMEOUT+1) bits) starts at 0 on WAIT entry and increments
//   each WAIT cycle; on reaching TIMEOUT with no do_ack: mem_en<=0, data_out<={DW{1'b1}}, err<=1,
//   dor<=1, -> HOLD. The counter clears on WAIT exit.
//  Not defined: no counter; WAIT waits indefinitely; err tied 0.
// TESTING
//  1 reset held 2 cycles, then dir=1,data_in=1 for 1 cycle; mem acks 2 cycles after mem_en with mem_do=8'hA5
//    -> ack_in pulse at n+1, mem_addr=1 at n+2, dor=1,data_out=A5 held until ack_out.
//  2 initiator-style loop: ack_out and dir(data_in=PC+1) in the same cycle, PCs 1..8
//    -> data_out sequence = mem[1..8] in order, no dropped addresses, overflow=0.
//  3 three dir pulses on consecutive cycles while FSM is in HOLD with QDEPTH=2
//    -> first two queued, third dropped; overflow=1 sticky; only two ack_in pulses.
//  4 reset asserted while in WAIT, then mem_do_ack pulses after reset drops
//    -> mem_en=0, dor=0 after the reset edge; the stray do_ack produces no dor.
//  5 FETCH_TIMEOUT_EN, TIMEOUT=16, memory never acks -> mem_en drops after 16 WAIT cycles,
//    dor=1, err=1, data_out=8'hFF; without the macro, mem_en is still high after 100 cycles.
//  6 ack_out pulsed while dor=0 -> no state change; the next fetch result is still presented and held.

Source files
------------

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Bundles every non-clock signal of fetch_stage: the initiator handshake
//   (dir/data_in/ack_in/overflow and dor/ack_out/data_out/err) and the
//   memory_controller device port (mem_en/mem_addr/mem_di/mem_do_ack/mem_do).
//
// Parameters
//   AW  address width (data_in, mem_addr)
//   DW  data width    (data_out, mem_di, mem_do)
//
// Modports
//   slave   fetch_stage side: responder to the initiator, requester to memory
//   master  environment side: the initiator plus the memory controller
// -----------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    // initiator -> fetch stage
    logic          dir;
    logic [AW-1:0] data_in;
    logic          ack_out;
    // fetch stage -> initiator
    logic          ack_in;
    logic          overflow;
    logic          dor;
    logic [DW-1:0] data_out;
    logic          err;
    // fetch stage <-> memory controller
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_di;
    logic          mem_do_ack;
    logic [DW-1:0] mem_do;

    modport slave (
        input  dir, data_in, ack_out, mem_do_ack, mem_do,
        output ack_in, overflow, dor, data_out, err, mem_en, mem_addr, mem_di
    );

    modport master (
        output dir, data_in, ack_out, mem_do_ack, mem_do,
        input  ack_in, overflow, dor, data_out, err, mem_en, mem_addr, mem_di
    );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Responder end of the DIR/DOR/ack pipeline handshake. Fetch addresses from
//   the initiator are queued, read one at a time through the memory
//   controller port, and each fetched byte is presented with dor held until
//   the initiator acks it. The queue lets the initiator issue a new address
//   in the same cycle it acks the previous result.
//
// Parameters
//   AW       address width
//   DW       data width
//   QDEPTH   address queue depth (power of 2, >= 2)
//   TIMEOUT  cycles mem_en may stay high before the fetch is aborted
//
// Ports
//   clk    clock, all logic on the rising edge
//   reset  synchronous, active-high reset
//   bus    fetch_stage_if.slave: initiator handshake and memory port
//
// Optional feature
//   FETCH_TIMEOUT_EN  when defined, a fetch with no mem_do_ack after TIMEOUT
//                     cycles is aborted and returned with err=1 and
//                     data_out all ones. When undefined, WAIT lasts until
//                     mem_do_ack and err is tied 0.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int QDEPTH  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    fetch_stage_if.slave bus
);
    localparam int IW = $clog2(QDEPTH);
    localparam int PW = IW + 1;

    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
        $error("fetch_stage: QDEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fetch_stage: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t state, state_next;

    // Address queue. The extra pointer bit tells full from empty.
    logic [AW-1:0] q_mem [QDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          empty, full, enq;

    // FSM control strobes
    logic launch;          // dequeue head and start a memory read
    logic capture;         // memory answered: latch data, raise dor
    logic abort_fetch;     // timeout: return error result
    logic release_result;  // initiator acked: drop dor
    logic timeout_hit;

    // Registered outputs
    logic          ack_in_q, overflow_q, dor_q, mem_en_q;
    logic [DW-1:0] data_out_q;
    logic [AW-1:0] mem_addr_q;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
    // A full queue still accepts when the head leaves in the same cycle.
    assign enq   = bus.dir && (!full || launch);

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (!empty) state_next = ST_WAIT;
            ST_WAIT: if (bus.mem_do_ack || timeout_hit) state_next = ST_HOLD;
            ST_HOLD: if (bus.ack_out) state_next = empty ? ST_IDLE : ST_WAIT;
            default: state_next = ST_IDLE;
        endcase
    end

    // ack_out only matters in HOLD (the only state with dor=1), and
    // mem_do_ack only in WAIT, so stray pulses elsewhere are ignored.
    always_comb begin
        launch         = 1'b0;
        capture        = 1'b0;
        abort_fetch    = 1'b0;
        release_result = 1'b0;
        unique case (state)
            ST_IDLE: launch = !empty;
            ST_WAIT: begin
                capture     = bus.mem_do_ack;
                abort_fetch = !bus.mem_do_ack && timeout_hit;
            end
            ST_HOLD: begin
                release_result = bus.ack_out;
                launch         = bus.ack_out && !empty;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------ wait timeout
`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    // The abort fires in the WAIT cycle whose increment would bring the
    // count to TIMEOUT, so mem_en stays high for exactly TIMEOUT cycles.
    assign timeout_hit = (state == ST_WAIT) && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= (state == ST_WAIT && state_next == ST_WAIT) ? wait_cnt + CW'(1) : '0;
            if (capture)     err_q <= 1'b0;
            if (abort_fetch) err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
`endif

    // -------------------------------------------------- queue storage
    // NOTE: the storage array has no reset; an entry is only read after it
    // was written, and the pointers (which are reset) decide validity.
    always_ff @(posedge clk) begin
        if (enq) q_mem[wr_ptr[IW-1:0]] <= bus.data_in;
    end

    // ------------------------------------------- pointers and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ack_in_q   <= 1'b0;
            overflow_q <= 1'b0;
            dor_q      <= 1'b0;
            mem_en_q   <= 1'b0;
            data_out_q <= '0;
            mem_addr_q <= '0;
        end else begin
            ack_in_q <= enq;
            if (bus.dir && !enq) overflow_q <= 1'b1;
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (launch) begin
                rd_ptr     <= rd_ptr + PW'(1);
                mem_en_q   <= 1'b1;
                mem_addr_q <= q_mem[rd_ptr[IW-1:0]];
            end
            if (capture) begin
                mem_en_q   <= 1'b0;
                data_out_q <= bus.mem_do;
                dor_q      <= 1'b1;
            end
            if (abort_fetch) begin
                mem_en_q   <= 1'b0;
                data_out_q <= '1;
                dor_q      <= 1'b1;
            end
            // launch and release share the HOLD exit; dor drops as the next
            // read starts, with no idle bubble in between.
            if (release_result) dor_q <= 1'b0;
        end
    end

    assign bus.ack_in   = ack_in_q;
    assign bus.overflow = overflow_q;
    assign bus.dor      = dor_q;
    assign bus.data_out = data_out_q;
    assign bus.mem_en   = mem_en_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_di   = '0;
endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. A memory responder answers reads with
//   mem_val(addr) after a programmable delay. A scoreboard holds the
//   addresses the initiator expects to be fetched, in order; one compare
//   process checks every fetch launch, every presented result and output
//   stability against it. Directed sequences add literal expectations for
//   latency, overflow, reset and timeout behaviour.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int QDEPTH  = 2;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_stage_if #(.AW(AW), .DW(DW)) bus ();

    fetch_stage #(
        .AW(AW), .DW(DW), .QDEPTH(QDEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents seen by the fetch stage.
    function automatic logic [7:0] mem_val(input logic [7:0] a);
        return a + 8'hA4;
    endfunction

    // ------------------------------------------------------- model state
    logic [7:0] exp_fetch[$];   // addresses expected to be fetched, in order
    logic [7:0] results[$];     // results seen at each dor rise
    int         resp_delay   = 2;
    bit         resp_on      = 1'b1;
    bit         stray_req    = 1'b0;
    bit         expect_abort = 1'b0;
    int         waited       = 0;

    // ---------------------------------------------- memory responder
    initial begin
        bus.mem_do_ack = 1'b0;
        bus.mem_do     = '0;
        forever begin
            @(negedge clk);
            bus.mem_do_ack = 1'b0;
            if (stray_req) begin
                bus.mem_do_ack = 1'b1;
                bus.mem_do     = 8'h3C;
                stray_req      = 1'b0;
            end else if (resp_on && bus.mem_en) begin
                if (waited >= resp_delay) begin
                    bus.mem_do_ack = 1'b1;
                    bus.mem_do     = mem_val(bus.mem_addr);
                    waited         = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
        end
    end

    // ------------------------------------------------ compare process
    logic       prev_mem_en = 1'b0;
    logic       prev_dor    = 1'b0;
    logic [7:0] cur_addr    = '0;
    logic [7:0] held        = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_fetch.delete();
                prev_mem_en = 1'b0;
                prev_dor    = 1'b0;
            end else begin
                if (bus.mem_en && !prev_mem_en) begin
                    check("fetch_expected", 32'(exp_fetch.size() != 0), 32'd1);
                    if (exp_fetch.size() != 0) begin
                        cur_addr = exp_fetch.pop_front();
                        check("mem_addr_order", 32'(bus.mem_addr), 32'(cur_addr));
                    end
                end else if (bus.mem_en) begin
                    check("mem_addr_stable", 32'(bus.mem_addr), 32'(cur_addr));
                end
                if (bus.mem_en) check("mem_di_zero", 32'(bus.mem_di), 32'd0);
                if (bus.dor && !prev_dor) begin
                    if (expect_abort) begin
                        check("abort_data", 32'(bus.data_out), 32'hFF);
                        check("abort_err", 32'(bus.err), 32'd1);
                    end else begin
                        check("result_data", 32'(bus.data_out), 32'(mem_val(cur_addr)));
                        check("result_err", 32'(bus.err), 32'd0);
                    end
                    results.push_back(bus.data_out);
                    held = bus.data_out;
                end else if (bus.dor) begin
                    check("data_out_stable", 32'(bus.data_out), 32'(held));
                end
                prev_mem_en = bus.mem_en;
                prev_dor    = bus.dor;
            end
        end
    end

    // ---------------------------------------------------- stimulus tasks
    task automatic send_pc(input logic [7:0] a, input bit accept);
        bus.dir     = 1'b1;
        bus.data_in = a;
        if (accept) exp_fetch.push_back(a);
        @(negedge clk);
        bus.dir = 1'b0;
    endtask

    task automatic wait_dor(input string name, input int budget);
        int n = 0;
        while (!bus.dor && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.dor), 32'd1);
    endtask

    task automatic wait_mem_en(input string name, input int budget);
        int n = 0;
        while (!bus.mem_en && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.mem_en), 32'd1);
    endtask

    task automatic ack_result();
        bus.ack_out = 1'b1;
        @(negedge clk);
        bus.ack_out = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------- sequences
    initial begin
        int acks;
        bus.dir     = 1'b0;
        bus.data_in = '0;
        bus.ack_out = 1'b0;
        reset       = 1'b1;

        // Reset held for two rising edges.
        repeat (2) @(negedge clk);
        check("rst_dor", 32'(bus.dor), 32'd0);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_ack_in", 32'(bus.ack_in), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        reset = 1'b0;

        // 1: single fetch, memory answers 2 cycles after mem_en.
        resp_delay  = 2;
        bus.dir     = 1'b1;
        bus.data_in = 8'd1;
        exp_fetch.push_back(8'd1);
        @(negedge clk);                       // n+1
        bus.dir = 1'b0;
        check("t1_ack_in_n1", 32'(bus.ack_in), 32'd1);
        check("t1_mem_en_n1", 32'(bus.mem_en), 32'd0);
        @(negedge clk);                       // n+2
        check("t1_ack_in_n2", 32'(bus.ack_in), 32'd0);
        check("t1_mem_en_n2", 32'(bus.mem_en), 32'd1);
        check("t1_mem_addr_n2", 32'(bus.mem_addr), 32'd1);
        @(negedge clk);                       // n+3
        check("t1_dor_n3", 32'(bus.dor), 32'd0);
        @(negedge clk);                       // n+4: memory acks
        check("t1_dor_n4", 32'(bus.dor), 32'd0);
        @(negedge clk);                       // n+5
        check("t1_dor_n5", 32'(bus.dor), 32'd1);
        check("t1_data_n5", 32'(bus.data_out), 32'hA5);
        check("t1_mem_en_n5", 32'(bus.mem_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_dor_held", 32'(bus.dor), 32'd1);
        end
        ack_result();
        check("t1_dor_after_ack", 32'(bus.dor), 32'd0);
        check("t1_mem_en_after_ack", 32'(bus.mem_en), 32'd0);

        // 6: ack_out while dor=0 (idle, then during WAIT) has no effect.
        ack_result();
        check("t6_idle_dor", 32'(bus.dor), 32'd0);
        check("t6_idle_mem_en", 32'(bus.mem_en), 32'd0);
        resp_delay = 3;
        send_pc(8'h20, 1'b1);
        @(negedge clk);
        check("t6_in_wait", 32'(bus.mem_en), 32'd1);
        ack_result();
        wait_dor("t6_dor", 20);
        check("t6_data", 32'(bus.data_out), 32'hC4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_dor_held", 32'(bus.dor), 32'd1);
        end
        ack_result();
        check("t6_dor_released", 32'(bus.dor), 32'd0);

        // 2: initiator loop, ack + next PC in the same cycle, zero-delay memory.
        resp_delay = 0;
        results.delete();
        send_pc(8'd1, 1'b1);
        for (int pc = 1; pc <= 8; pc++) begin
            wait_dor("t2_dor", 20);
            bus.ack_out = 1'b1;
            if (pc < 8) send_pc(8'(pc + 1), 1'b1);
            else        @(negedge clk);
            bus.ack_out = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("t2_result_count", 32'(results.size()), 32'd8);
        for (int i = 0; i < results.size() && i < 8; i++)
            check("t2_result_seq", 32'(results[i]), 32'(mem_val(8'(i + 1))));
        if (results.size() == 8) begin
            check("t2_first_literal", 32'(results[0]), 32'hA5);
            check("t2_last_literal", 32'(results[7]), 32'hAC);
        end
        check("t2_overflow", 32'(bus.overflow), 32'd0);

        // 3: three dir pulses while holding a result: two queue, one drops.
        resp_delay = 1;
        send_pc(8'h40, 1'b1);
        wait_dor("t3_dor", 20);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                bus.dir     = 1'b1;
                bus.data_in = 8'(8'h41 + i);
                if (i < 2) exp_fetch.push_back(8'(8'h41 + i));
            end else begin
                bus.dir = 1'b0;
            end
            @(negedge clk);
            acks += int'(bus.ack_in);
        end
        @(negedge clk);
        acks += int'(bus.ack_in);
        check("t3_ack_in_count", 32'(acks), 32'd2);
        check("t3_overflow", 32'(bus.overflow), 32'd1);
        check("t3_still_holding", 32'(bus.dor), 32'd1);
        // Queue full: ack + dir in one cycle frees a slot and takes the PC.
        bus.ack_out = 1'b1;
        send_pc(8'h44, 1'b1);
        bus.ack_out = 1'b0;
        check("t3_full_enq_ack_in", 32'(bus.ack_in), 32'd1);
        check("t3_b2b_dor", 32'(bus.dor), 32'd0);
        check("t3_b2b_mem_en", 32'(bus.mem_en), 32'd1);
        check("t3_b2b_mem_addr", 32'(bus.mem_addr), 32'h41);
        for (int i = 0; i < 3; i++) begin
            wait_dor("t3_queued_dor", 20);
            ack_result();
        end
        repeat (2) @(negedge clk);
        check("t3_overflow_sticky", 32'(bus.overflow), 32'd1);
        check("t3_queue_drained", 32'(exp_fetch.size()), 32'd0);
        do_reset(2);
        check("t3_overflow_reset", 32'(bus.overflow), 32'd0);

        // 4: reset during WAIT abandons the fetch; a late do_ack is ignored.
        resp_on = 1'b0;
        send_pc(8'h50, 1'b1);
        wait_mem_en("t4_mem_en", 10);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t4_reset_mem_en", 32'(bus.mem_en), 32'd0);
        check("t4_reset_dor", 32'(bus.dor), 32'd0);
        reset     = 1'b0;
        stray_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_stray_dor", 32'(bus.dor), 32'd0);
            check("t4_stray_mem_en", 32'(bus.mem_en), 32'd0);
        end

        // 5: memory never answers.
`ifdef FETCH_TIMEOUT_EN
        expect_abort = 1'b1;
        send_pc(8'h60, 1'b1);
        wait_mem_en("t5_mem_en", 10);
        acks = 0;
        while (bus.mem_en && acks < 100) begin
            acks++;
            @(negedge clk);
        end
        check("t5_wait_cycles", 32'(acks), 32'd16);
        check("t5_dor", 32'(bus.dor), 32'd1);
        check("t5_err", 32'(bus.err), 32'd1);
        check("t5_data", 32'(bus.data_out), 32'hFF);
        ack_result();
        expect_abort = 1'b0;
        check("t5_released", 32'(bus.dor), 32'd0);
`else
        send_pc(8'h60, 1'b1);
        repeat (100) @(negedge clk);
        check("t5_mem_en_held", 32'(bus.mem_en), 32'd1);
        check("t5_no_dor", 32'(bus.dor), 32'd0);
        check("t5_err_tied", 32'(bus.err), 32'd0);
`endif
        resp_on = 1'b1;
        do_reset(2);

        // After a reset, a fresh fetch still works end to end.
        resp_delay = 2;
        send_pc(8'h07, 1'b1);
        wait_dor("post_reset_dor", 20);
        check("post_reset_data", 32'(bus.data_out), 32'hAB);
        ack_result();
        repeat (2) @(negedge clk);
        check("final_queue_empty", 32'(exp_fetch.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
